// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the accepted-key handshake toward the consumer.
// slave is the scanner side; master is the keypad/consumer side.
interface keypad_scanner_if;
  logic [4:0] col_in;
  logic [6:0] row_drive;
  logic [5:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;

  modport slave (
    input  col_in, key_ack,
    output row_drive, key_code, key_valid, key_held
  );

  modport master (
    output col_in, key_ack,
    input  row_drive, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 7x5 matrix keypad scanner: one row driven low per dwell, debounced press/release
// detection on a frozen row, single-delivery key_code/key_valid handshake.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clock,
  input  logic            internal_reset,
  keypad_scanner_if.slave kp
);

  localparam int                TICK_W     = $clog2(SCAN_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_TICKS - 1);
  localparam logic [3:0]        DEB_TARGET = 4'(DEBOUNCE_SCANS);
  localparam logic [2:0]        ROW_LAST   = 3'd6;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state, state_n;
  logic [4:0]        col_p0, col_p1;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [2:0]        row, row_n;
  logic [6:0]        row_drive, row_drive_n;
  logic [2:0]        cand_col, cand_col_n;
  logic [5:0]        cand_code, cand_code_n;
  logic [3:0]        match_cnt, match_cnt_n;
  logic [5:0]        key_code, key_code_n;
  logic              key_valid, key_valid_n;
  logic              key_held, key_held_n;
  logic              sample, col_hit, cand_low;
  logic [2:0]        low_col;
  logic [3:0]        cnt_inc;

  function automatic logic [2:0] lowest_low(input logic [4:0] cols);
    lowest_low = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (!cols[i]) lowest_low = 3'(i);
  endfunction

  function automatic logic [6:0] row_select(input logic [2:0] r);
    row_select = ~(7'b1 << r);
  endfunction

  function automatic logic [2:0] row_advance(input logic [2:0] r);
    row_advance = (r == ROW_LAST) ? 3'd0 : r + 3'd1;
  endfunction

  function automatic logic [5:0] key_index(input logic [2:0] r, input logic [2:0] c);
    key_index = 6'(r) * 6'd5 + 6'(c);
  endfunction

  // Stage p0/p1: columns are asynchronous; idle (pulled-up) level is all ones
  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      col_p0 <= '1;
      col_p1 <= '1;
    end else begin
      col_p0 <= kp.col_in;
      col_p1 <= col_p0;
    end
  end

  assign sample   = (tick_cnt == TICK_LAST);
  assign col_hit  = (col_p1 != 5'h1f);
  assign low_col  = lowest_low(col_p1);
  assign cand_low = !col_p1[cand_col];
  assign cnt_inc  = match_cnt + 4'd1;

  always_comb begin
    state_n     = state;
    tick_cnt_n  = sample ? '0 : tick_cnt + TICK_W'(1);
    row_n       = row;
    cand_col_n  = cand_col;
    cand_code_n = cand_code;
    match_cnt_n = match_cnt;
    key_code_n  = key_code;
    key_held_n  = key_held;
    // An acceptance below overrides this clear; the two never meet in practice
    key_valid_n = (key_valid && kp.key_ack) ? 1'b0 : key_valid;

    if (sample) begin
      case (state)
        SCAN: begin
          if (!key_valid && col_hit) begin
            cand_col_n  = low_col;
            cand_code_n = key_index(row, low_col);
            match_cnt_n = '0;
            state_n     = DEBOUNCE;
          end else begin
            row_n = row_advance(row);
          end
        end
        DEBOUNCE: begin
          if (cand_low) begin
            match_cnt_n = cnt_inc;
            if (cnt_inc == DEB_TARGET) begin
              key_code_n  = cand_code;
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
              state_n     = HELD;
            end
          end else begin
            state_n = SCAN;
            row_n   = row_advance(row);
          end
        end
        HELD: begin
          if (!cand_low) begin
            match_cnt_n = '0;
            state_n     = RELEASE;
          end
        end
        RELEASE: begin
          if (!cand_low) begin
            match_cnt_n = cnt_inc;
            if (cnt_inc == DEB_TARGET) begin
              key_held_n = 1'b0;
              state_n    = SCAN;
              row_n      = row_advance(row);
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase
    end

    row_drive_n = row_select(row_n);
  end

  always_ff @(posedge clock or posedge internal_reset) begin
    if (internal_reset) begin
      state     <= SCAN;
      tick_cnt  <= '0;
      row       <= '0;
      row_drive <= 7'b1111110;
      cand_col  <= '0;
      cand_code <= '0;
      match_cnt <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      row       <= row_n;
      row_drive <= row_drive_n;
      cand_col  <= cand_col_n;
      cand_code <= cand_code_n;
      match_cnt <= match_cnt_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
    end
  end

  assign kp.row_drive = row_drive;
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;

endmodule
